// File: rtl/ps2_rx_deserializer_if.sv
// Receive-side bus of the PS/2 deserializer: enable from the transmitter,
// and received byte, strobes and busy flag towards mousecontroler.
interface ps2_rx_deserializer_if;
    logic       rx_en;
    logic [7:0] dato;
    logic       dato_recibido;
    logic       rx_error;
    logic       rx_busy;

    modport master (
        input  rx_en,
        output dato,
        output dato_recibido,
        output rx_error,
        output rx_busy
    );

    modport slave (
        output rx_en,
        input  dato,
        input  dato_recibido,
        input  rx_error,
        input  rx_busy
    );
endinterface

// File: rtl/ps2_rx_deserializer.sv
// PS/2 device-to-host receiver: pin synchronisation, clock glitch filter,
// 11-bit frame deserialisation with start/parity/stop checks and a frame timeout.
module ps2_rx_deserializer #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clkps2,
    input  logic                  dataps2,
    ps2_rx_deserializer_if.master bus
);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        CHECK
    } state_t;

    logic                  clk_s1, clk_s2, dat_s1, dat_s2;
    logic [FILTER_LEN-1:0] filt;
    logic                  clk_f, clk_f_d;
    logic                  fall;

    state_t       state, state_n;
    logic [3:0]   bit_cnt, bit_cnt_n;
    logic [TW-1:0] to_cnt, to_cnt_n;
    logic [8:0]   frame, frame_n;
    logic [7:0]   dato_q, dato_n;
    logic         ok_q, ok_n;
    logic         err_q, err_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            dat_s1  <= 1'b1;
            dat_s2  <= 1'b1;
            filt    <= '1;
            clk_f   <= 1'b1;
            clk_f_d <= 1'b1;
        end else begin
            clk_s1  <= clkps2;
            clk_s2  <= clk_s1;
            dat_s1  <= dataps2;
            dat_s2  <= dat_s1;
            filt    <= {filt[FILTER_LEN-2:0], clk_s2};
            if (&filt)
                clk_f <= 1'b1;
            else if (~|filt)
                clk_f <= 1'b0;
            clk_f_d <= clk_f;
        end
    end

    assign fall = clk_f_d & ~clk_f;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            to_cnt  <= '0;
            frame   <= '0;
            dato_q  <= '0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            to_cnt  <= to_cnt_n;
            frame   <= frame_n;
            dato_q  <= dato_n;
            ok_q    <= ok_n;
            err_q   <= err_n;
        end
    end

    // The verdict is taken on the stop-bit fall (stop bit used live, not shifted in),
    // so the registered strobe and the new dato both appear during CHECK.
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        to_cnt_n  = to_cnt;
        frame_n   = frame;
        dato_n    = dato_q;
        ok_n      = 1'b0;
        err_n     = 1'b0;
        case (state)
            IDLE: begin
                if (fall && bus.rx_en && !dat_s2) begin
                    state_n   = RECV;
                    bit_cnt_n = '0;
                    to_cnt_n  = '0;
                end
            end
            RECV: begin
                if (!bus.rx_en) begin
                    state_n = IDLE;
                end else if (fall) begin
                    to_cnt_n  = '0;
                    bit_cnt_n = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd9) begin
                        state_n = CHECK;
                        if (dat_s2 && (^frame)) begin
                            ok_n   = 1'b1;
                            dato_n = frame[7:0];
                        end else begin
                            err_n = 1'b1;
                        end
                    end else begin
                        frame_n = {dat_s2, frame[8:1]};
                    end
                end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_n = IDLE;
                    err_n   = 1'b1;
                end else begin
                    to_cnt_n = to_cnt + 1'b1;
                end
            end
            CHECK: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.dato          = dato_q;
    assign bus.dato_recibido = ok_q;
    assign bus.rx_error      = err_q;
    assign bus.rx_busy       = (state != IDLE);
endmodule

// File: tb/tb_ps2_rx_deserializer.sv
// Randomised frame-level bench for ps2_rx_deserializer; expected bytes and errors
// come from a frame model applied to each frame the bench sends.
module tb_ps2_rx_deserializer;
    localparam int FILT = 8;
    localparam int TMO  = 400;
    localparam int HALF = 40;

    logic clk     = 1'b0;
    logic reset   = 1'b0;
    logic clkps2  = 1'b1;
    logic dataps2 = 1'b1;

    ps2_rx_deserializer_if bus ();

    ps2_rx_deserializer #(
        .FILTER_LEN     (FILT),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .clkps2  (clkps2),
        .dataps2 (dataps2),
        .bus     (bus)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // model state
    logic [7:0] exp_q[$];
    int         exp_err  = 0;
    logic [7:0] ref_dato = 8'h00;

    // observed events
    logic [7:0] obs_q[$];
    int         n_err_obs     = 0;
    int         last_fall_cyc = 0;
    int         last_err_cyc  = 0;
    logic       prev_ok       = 1'b0;
    logic       prev_err      = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            prev_ok  = 1'b0;
            prev_err = 1'b0;
        end else begin
            if (bus.dato_recibido) begin
                check("excl", bus.rx_error, 0);
                check("ok_width", prev_ok, 0);
                check("ok_latency",
                      ((cyc - last_fall_cyc) >= FILT + 3) && ((cyc - last_fall_cyc) <= FILT + 5), 1);
                obs_q.push_back(bus.dato);
            end
            if (bus.rx_error) begin
                check("err_width", prev_err, 0);
                n_err_obs++;
                last_err_cyc = cyc;
            end
            prev_ok  = bus.dato_recibido;
            prev_err = bus.rx_error;
        end
    end

    function automatic logic [10:0] make_frame(input logic [7:0] b, input bit par_bad, input bit stop_bad);
        logic p;
        p = (($countones(b) % 2) == 0) ? 1'b1 : 1'b0;
        return {~stop_bad, p ^ par_bad, b, 1'b0};
    endfunction

    task automatic send_frame(input logic [10:0] bits, input int nbits, input int glitch_bit,
                              input int abort_bit);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            clkps2  = 1'b1;
            dataps2 = bits[i];
            if (i == glitch_bit) begin
                repeat (HALF / 2) @(negedge clk);
                clkps2 = 1'b0;
                repeat (4) @(negedge clk);
                clkps2 = 1'b1;
                repeat (HALF / 2 - 4) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            clkps2        = 1'b0;
            last_fall_cyc = cyc;
            if (i == abort_bit) begin
                repeat (20) @(negedge clk);
                check("busy_pre_abort", bus.rx_busy, 1);
                bus.rx_en = 1'b0;
                @(negedge clk);
                check("busy_abort", bus.rx_busy, 0);
                repeat (HALF - 21) @(negedge clk);
            end else begin
                repeat (HALF - 1) @(negedge clk);
            end
        end
        @(negedge clk);
        clkps2  = 1'b1;
        dataps2 = 1'b1;
    endtask

    task automatic apply_frame(input logic [7:0] b, input bit par_bad, input bit stop_bad,
                               input int glitch_bit);
        logic [10:0] f;
        logic [8:0]  body;
        f    = make_frame(b, par_bad, stop_bad);
        body = f[9:1];
        send_frame(f, 11, glitch_bit, -1);
        if (f[0] == 1'b0 && f[10] == 1'b1 && ($countones(body) % 2) == 1) begin
            exp_q.push_back(body[7:0]);
            ref_dato = body[7:0];
        end else begin
            exp_err++;
        end
    endtask

    task automatic verify(input string tag);
        repeat (30) @(negedge clk);
        check({tag, "_n_ok"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check({tag, "_byte"}, obs_q[i], exp_q[i]);
        check({tag, "_n_err"}, n_err_obs, exp_err);
        check({tag, "_dato"}, bus.dato, ref_dato);
        check({tag, "_busy_idle"}, bus.rx_busy, 0);
        obs_q.delete();
        exp_q.delete();
        n_err_obs = 0;
        exp_err   = 0;
    endtask

    initial begin
        repeat (200000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.rx_en = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_dato", bus.dato, 0);
        check("rst_ok", bus.dato_recibido, 0);
        check("rst_err", bus.rx_error, 0);
        check("rst_busy", bus.rx_busy, 0);
        reset = 1'b1;
        repeat (20) @(negedge clk);

        // falls with data high while idle are ignored
        send_frame(11'h7FF, 3, -1, -1);
        verify("idle_ones");

        apply_frame(8'hFA, 0, 0, -1);
        verify("fa");

        apply_frame(8'h08, 0, 0, -1);
        apply_frame(8'h00, 0, 0, -1);
        apply_frame(8'hFF, 0, 0, -1);
        verify("b2b");

        // 0x55 has four ones: bad parity, then good parity with a bad stop bit
        apply_frame(8'h55, 1, 0, -1);
        verify("par_bad");
        apply_frame(8'h55, 0, 1, -1);
        verify("stop_bad");

        send_frame(make_frame(8'h33, 0, 0), 5, -1, -1);
        repeat (2 * TMO) @(negedge clk);
        exp_err++;
        check("timeout_latency",
              ((last_err_cyc - last_fall_cyc) >= TMO + FILT + 2) &&
              ((last_err_cyc - last_fall_cyc) <= TMO + FILT + 6), 1);
        apply_frame(8'hAA, 0, 0, -1);
        verify("timeout");

        apply_frame(8'h3C, 0, 0, 4);
        verify("glitch");

        send_frame(make_frame(8'h5A, 0, 0), 11, -1, 3);
        bus.rx_en = 1'b1;
        verify("abort");

        send_frame(make_frame(8'h81, 0, 0), 4, -1, -1);
        repeat (20) @(negedge clk);
        check("busy_pre_reset", bus.rx_busy, 1);
        #3 reset = 1'b0;
        #1;
        check("async_rst_dato", bus.dato, 0);
        check("async_rst_ok", bus.dato_recibido, 0);
        check("async_rst_err", bus.rx_error, 0);
        check("async_rst_busy", bus.rx_busy, 0);
        ref_dato = 8'h00;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        apply_frame(8'h81, 0, 0, -1);
        verify("post_reset");

        for (int k = 0; k < 24; k++) begin
            logic [7:0] b;
            bit         pb, sb;
            int         g;
            b  = 8'($urandom);
            pb = ($urandom_range(0, 3) == 0);
            sb = ($urandom_range(0, 7) == 0);
            g  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : -1;
            apply_frame(b, pb, sb, g);
            verify("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
